// File: rtl/baralho_embaralhador.sv
// Multi-deck card store with LFSR-driven in-place Fisher-Yates shuffle.
// Optional: define AUTO_REEMBARALHO_EN to refill/reshuffle automatically once empty.
module baralho_embaralhador #(
    parameter int                      NUM_BARALHOS = 1,
    parameter int                      LARGURA_LFSR = 16,
    parameter logic [LARGURA_LFSR-1:0] SEMENTE      = 16'hACE1
) (
    input  logic       clock,
    input  logic       resetar,
    input  logic       embaralhar,
    input  logic       pedirCarta,
    output logic [3:0] carta,
    output logic       cartaValida,
    output logic       embaralhamentoPronto,
    output logic       baralhoVazio,
    output logic [8:0] cartasRestantes
);

    localparam int N     = 52 * NUM_BARALHOS;
    localparam int AW    = $clog2(N);
    localparam int DEPTH = 1 << AW;

    localparam logic [LARGURA_LFSR-1:0] POLY = LARGURA_LFSR'(16'hB400);
    localparam logic [LARGURA_LFSR-1:0] SEED =
        (SEMENTE == '0) ? LARGURA_LFSR'(1) : SEMENTE;
    localparam logic [AW-1:0] ULTIMO = AW'(N - 1);
    localparam logic [8:0]    TOTAL  = 9'(N);

    typedef enum logic [2:0] {
        OCIOSO,
        INICIALIZA,
        SORTEIA,
        LE,
        ESCREVE,
        PRONTO
    } estado_t;

    estado_t                 estado_q, estado_d;
    logic [LARGURA_LFSR-1:0] lfsr_q, lfsr_d;
    logic [AW-1:0]           k_q, k_d;
    logic [3:0]              c13_q, c13_d;
    logic [AW-1:0]           i_q, i_d;
    logic [AW-1:0]           j_q, j_d;
    logic [3:0]              a_q, a_d;
    logic [3:0]              b_q, b_d;
    logic [AW-1:0]           ptr_q, ptr_d;
    logic [8:0]              rest_q, rest_d;
    logic [3:0]              carta_q, carta_d;
    logic                    valida_q, valida_d;

    logic [3:0]    mem [DEPTH];
    logic          we_init;
    logic          we_swap;
    logic [3:0]    valor_init;
    logic [AW-1:0] j_cand;

    // All ones from bit 0 up to the highest set bit of v.
    function automatic logic [AW-1:0] mascara(input logic [AW-1:0] v);
        logic [AW-1:0] m;
        m = '0;
        for (int b = 0; b < AW; b++) begin
            m[b] = |(v >> b);
        end
        return m;
    endfunction

    assign lfsr_d     = {1'b0, lfsr_q[LARGURA_LFSR-1:1]} ^ (lfsr_q[0] ? POLY : '0);
    assign valor_init = (c13_q < 4'd9) ? c13_q + 4'd1 : 4'd10;
    assign j_cand     = lfsr_q[AW-1:0] & mascara(i_q);

    always_comb begin
        estado_d = estado_q;
        k_d      = k_q;
        c13_d    = c13_q;
        i_d      = i_q;
        j_d      = j_q;
        a_d      = a_q;
        b_d      = b_q;
        ptr_d    = ptr_q;
        rest_d   = rest_q;
        carta_d  = carta_q;
        valida_d = 1'b0;
        we_init  = 1'b0;
        we_swap  = 1'b0;

        // A shuffle request overrides everything, including a pending draw.
        if (embaralhar) begin
            estado_d = INICIALIZA;
            k_d      = '0;
            c13_d    = '0;
            rest_d   = '0;
        end else begin
            unique case (estado_q)
                OCIOSO: begin
                end
                INICIALIZA: begin
                    we_init = 1'b1;
                    if (k_q == ULTIMO) begin
                        estado_d = SORTEIA;
                        i_d      = ULTIMO;
                    end else begin
                        k_d   = k_q + AW'(1);
                        c13_d = (c13_q == 4'd12) ? 4'd0 : c13_q + 4'd1;
                    end
                end
                SORTEIA: begin
                    if (j_cand <= i_q) begin
                        j_d      = j_cand;
                        estado_d = LE;
                    end
                end
                LE: begin
                    a_d      = mem[i_q];
                    b_d      = mem[j_q];
                    estado_d = ESCREVE;
                end
                ESCREVE: begin
                    we_swap = 1'b1;
                    i_d     = i_q - AW'(1);
                    if (i_q == AW'(1)) begin
                        estado_d = PRONTO;
                        ptr_d    = '0;
                        rest_d   = TOTAL;
                    end else begin
                        estado_d = SORTEIA;
                    end
                end
                PRONTO: begin
                    if (pedirCarta && rest_q != '0) begin
                        carta_d  = mem[ptr_q];
                        valida_d = 1'b1;
                        ptr_d    = ptr_q + AW'(1);
                        rest_d   = rest_q - 9'd1;
                    end
`ifdef AUTO_REEMBARALHO_EN
                    else if (rest_q == '0) begin
                        estado_d = INICIALIZA;
                        k_d      = '0;
                        c13_d    = '0;
                    end
`endif
                end
                default: estado_d = OCIOSO;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (resetar) begin
            estado_q <= OCIOSO;
            lfsr_q   <= SEED;
            k_q      <= '0;
            c13_q    <= '0;
            i_q      <= '0;
            j_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ptr_q    <= '0;
            rest_q   <= '0;
            carta_q  <= '0;
            valida_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            lfsr_q   <= lfsr_d;
            k_q      <= k_d;
            c13_q    <= c13_d;
            i_q      <= i_d;
            j_q      <= j_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ptr_q    <= ptr_d;
            rest_q   <= rest_d;
            carta_q  <= carta_d;
            valida_q <= valida_d;
        end
    end

    // Contents are don't-care after reset, so the array has no reset.
    always_ff @(posedge clock) begin
        if (we_init) begin
            mem[k_q] <= valor_init;
        end
        if (we_swap) begin
            mem[i_q] <= b_q;
            mem[j_q] <= a_q;
        end
    end

    assign carta                = carta_q;
    assign cartaValida          = valida_q;
    assign embaralhamentoPronto = (estado_q == PRONTO);
    assign baralhoVazio         = (rest_q == '0);
    assign cartasRestantes      = rest_q;

endmodule

// File: tb/tb_baralho_embaralhador.sv
// Self-checking bench for baralho_embaralhador: one-deck and two-deck (seed 0) instances.
module tb_baralho_embaralhador;

    localparam int N1 = 52;
    localparam int N2 = 104;

    logic       clock = 1'b0;
    logic       rst;
    logic       emb;
    logic       req;
    logic       sel;

    logic       emb1, ped1, emb2, ped2;
    logic [3:0] carta1, carta2;
    logic       v1, v2, p1, p2, z1, z2;
    logic [8:0] r1, r2;

    logic [3:0] o_carta;
    logic       o_valid, o_pronto, o_vazio;
    logic [8:0] o_rest;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    logic [3:0] cap_q[$];
    logic [3:0] ref_q[$];
    int hist[16];

    always #5 clock = ~clock;

    assign emb1 = emb & ~sel;
    assign ped1 = req & ~sel;
    assign emb2 = emb & sel;
    assign ped2 = req & sel;

    assign o_carta  = sel ? carta2 : carta1;
    assign o_valid  = sel ? v2 : v1;
    assign o_pronto = sel ? p2 : p1;
    assign o_vazio  = sel ? z2 : z1;
    assign o_rest   = sel ? r2 : r1;

    baralho_embaralhador dut (
        .clock               (clock),
        .resetar             (rst),
        .embaralhar          (emb1),
        .pedirCarta          (ped1),
        .carta               (carta1),
        .cartaValida         (v1),
        .embaralhamentoPronto(p1),
        .baralhoVazio        (z1),
        .cartasRestantes     (r1)
    );

    baralho_embaralhador #(
        .NUM_BARALHOS(2),
        .SEMENTE     (16'h0000)
    ) dut2 (
        .clock               (clock),
        .resetar             (rst),
        .embaralhar          (emb2),
        .pedirCarta          (ped2),
        .carta               (carta2),
        .cartaValida         (v2),
        .embaralhamentoPronto(p2),
        .baralhoVazio        (z2),
        .cartasRestantes     (r2)
    );

    task automatic start_shuffle();
        @(negedge clock);
        emb = 1'b1;
        @(negedge clock);
        emb = 1'b0;
    endtask

    task automatic wait_ready(output bit ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clock);
            cyc++;
            if (o_pronto === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Back-to-back requests; expected remaining count queued per request.
    task automatic draw_all(input int n);
        int e;
        int cnt;
        int nb;
        cnt = 0;
        nb  = n / 52;
        foreach (hist[v]) hist[v] = 0;
        cap_q.delete();
        exp_q.delete();
        for (int c = 0; c < n + 2; c++) begin
            @(negedge clock);
            if (o_valid === 1'b1) cnt++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if (o_valid !== 1'b1 || o_rest !== 9'(e) ||
                    o_carta < 4'd1 || o_carta > 4'd10) begin
                    n_err++;
                    $display("FAIL draw_%0d: valid=%b rest=%0d carta=%0d, required valid=1 rest=%0d carta 1..10",
                             c, o_valid, o_rest, o_carta, e);
                end
                hist[o_carta]++;
                cap_q.push_back(o_carta);
            end
            if (c < n) begin
                req = 1'b1;
                exp_q.push_back(n - 1 - c);
            end else begin
                req = 1'b0;
            end
        end
        n_cmp++;
        if (cnt !== n) begin
            n_err++;
            $display("FAIL strobe_count: got %0d, required %0d", cnt, n);
        end
        for (int v = 1; v <= 10; v++) begin
            e = (v < 10) ? 4 * nb : 16 * nb;
            n_cmp++;
            if (hist[v] !== e) begin
                n_err++;
                $display("FAIL hist_%0d: got %0d, required %0d", v, hist[v], e);
            end
        end
        n_cmp++;
        if (o_vazio !== 1'b1 || o_rest !== 9'd0) begin
            n_err++;
            $display("FAIL empty_after_last: vazio=%b rest=%0d, required 1 and 0", o_vazio, o_rest);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (o_carta !== 4'd0 || o_valid !== 1'b0 || o_pronto !== 1'b0 ||
            o_rest !== 9'd0 || o_vazio !== 1'b1) begin
            n_err++;
            $display("FAIL reset: carta=%0d valid=%b pronto=%b rest=%0d vazio=%b, required 0 0 0 0 1",
                     o_carta, o_valid, o_pronto, o_rest, o_vazio);
        end
        rst = 1'b0;
        repeat (4) @(negedge clock);
        n_cmp++;
        if (o_pronto !== 1'b0 || o_rest !== 9'd0) begin
            n_err++;
            $display("FAIL idle: pronto=%b rest=%0d, required 0 and 0", o_pronto, o_rest);
        end
    endtask

    task automatic test_shuffle_draw();
        bit ok;
        int cyc;
        int diff;
        int m;
        sel = 1'b0;
        start_shuffle();
        wait_ready(ok, cyc);
        n_cmp++;
        if (!ok || o_rest !== 9'(N1)) begin
            n_err++;
            $display("FAIL ready_1: ok=%0d rest=%0d, required ok=1 rest=%0d", ok, o_rest, N1);
        end
        n_cmp++;
        if (cyc < N1 + 3 * (N1 - 1)) begin
            n_err++;
            $display("FAIL shuffle_time: got %0d cycles, required >= %0d", cyc, N1 + 3 * (N1 - 1));
        end
        draw_all(N1);
        diff = 0;
        for (int k = 0; k < N1; k++) begin
            m = k % 13;
            if (cap_q[k] !== 4'((m < 9) ? m + 1 : 10)) diff++;
        end
        n_cmp++;
        if (diff == 0) begin
            n_err++;
            $display("FAIL shuffled: got %0d positions moved, required > 0", diff);
        end
    endtask

    task automatic test_after_last();
        logic [3:0] last;
        bit ok;
        int cyc;
        last = o_carta;
        req  = 1'b1;
        @(negedge clock);
        req = 1'b0;
`ifdef AUTO_REEMBARALHO_EN
        n_cmp++;
        if (o_valid !== 1'b0 || o_pronto !== 1'b0) begin
            n_err++;
            $display("FAIL auto_restart: valid=%b pronto=%b, required 0 0", o_valid, o_pronto);
        end
        wait_ready(ok, cyc);
        n_cmp++;
        if (!ok || o_rest !== 9'(N1)) begin
            n_err++;
            $display("FAIL auto_ready: ok=%0d rest=%0d, required ok=1 rest=%0d", ok, o_rest, N1);
        end
`else
        ok  = 1'b1;
        cyc = 0;
        n_cmp++;
        if (o_valid !== 1'b0 || o_carta !== last || o_rest !== 9'd0 ||
            o_vazio !== 1'b1 || o_pronto !== 1'b1) begin
            n_err++;
            $display("FAIL draw_empty: valid=%b carta=%0d rest=%0d vazio=%b pronto=%b, required 0 %0d 0 1 1",
                     o_valid, o_carta, o_rest, o_vazio, o_pronto, last);
        end
        repeat (3) @(negedge clock);
        n_cmp++;
        if (o_pronto !== 1'b1 || o_carta !== last || o_vazio !== 1'b1) begin
            n_err++;
            $display("FAIL stay_empty: pronto=%b carta=%0d vazio=%b, required 1 %0d 1",
                     o_pronto, o_carta, o_vazio, last);
        end
`endif
    endtask

    task automatic do_run();
        bit ok;
        int cyc;
        rst = 1'b1;
        repeat (2) @(negedge clock);
        rst = 1'b0;
        repeat (7) @(negedge clock);
        start_shuffle();
        wait_ready(ok, cyc);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL run_ready: got ok=%0d, required 1", ok);
        end
        draw_all(N1);
    endtask

    task automatic test_reproducibility();
        logic [3:0] e;
        int same;
        sel = 1'b0;
        do_run();
        ref_q = cap_q;
        do_run();
        same = 1;
        for (int k = 0; k < N1; k++) begin
            e = ref_q.pop_front();
            n_cmp++;
            if (cap_q[k] !== e) begin
                n_err++;
                same = 0;
                $display("FAIL repro_%0d: got %0d, required %0d", k, cap_q[k], e);
            end
        end
    endtask

    task automatic test_abort();
        bit ok;
        int cyc;
        sel = 1'b0;
        start_shuffle();
        repeat (N1 + 30) @(negedge clock);
        emb = 1'b1;
        @(negedge clock);
        emb = 1'b0;
        n_cmp++;
        if (o_pronto !== 1'b0 || o_rest !== 9'd0) begin
            n_err++;
            $display("FAIL abort_shuffle: pronto=%b rest=%0d, required 0 0", o_pronto, o_rest);
        end
        wait_ready(ok, cyc);
        n_cmp++;
        if (!ok || o_rest !== 9'(N1)) begin
            n_err++;
            $display("FAIL abort_ready: ok=%0d rest=%0d, required ok=1 rest=%0d", ok, o_rest, N1);
        end
        emb = 1'b1;
        req = 1'b1;
        @(negedge clock);
        emb = 1'b0;
        req = 1'b0;
        n_cmp++;
        if (o_valid !== 1'b0 || o_pronto !== 1'b0 || o_rest !== 9'd0) begin
            n_err++;
            $display("FAIL abort_draw: valid=%b pronto=%b rest=%0d, required 0 0 0",
                     o_valid, o_pronto, o_rest);
        end
        wait_ready(ok, cyc);
        n_cmp++;
        if (!ok || o_rest !== 9'(N1)) begin
            n_err++;
            $display("FAIL abort_ready2: ok=%0d rest=%0d, required ok=1 rest=%0d", ok, o_rest, N1);
        end
        draw_all(N1);
    endtask

    task automatic test_reset_mid_shuffle();
        sel = 1'b0;
        start_shuffle();
        repeat (N1 + 20) @(negedge clock);
        rst = 1'b1;
        repeat (3) @(negedge clock);
        n_cmp++;
        if (o_carta !== 4'd0 || o_pronto !== 1'b0 || o_vazio !== 1'b1 ||
            o_rest !== 9'd0 || o_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_mid: carta=%0d pronto=%b vazio=%b rest=%0d valid=%b, required 0 0 1 0 0",
                     o_carta, o_pronto, o_vazio, o_rest, o_valid);
        end
        rst = 1'b0;
        repeat (300) @(negedge clock);
        n_cmp++;
        if (o_pronto !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle: pronto=%b, required 0", o_pronto);
        end
    endtask

    task automatic test_two_decks_seed0();
        bit ok;
        int cyc;
        sel = 1'b1;
        start_shuffle();
        wait_ready(ok, cyc);
        n_cmp++;
        if (!ok || o_rest !== 9'(N2)) begin
            n_err++;
            $display("FAIL ready_2: ok=%0d rest=%0d, required ok=1 rest=%0d", ok, o_rest, N2);
        end
        draw_all(N2);
`ifdef AUTO_REEMBARALHO_EN
        n_cmp++;
        if (o_pronto !== 1'b0) begin
            n_err++;
            $display("FAIL auto2_restart: pronto=%b, required 0", o_pronto);
        end
        wait_ready(ok, cyc);
        n_cmp++;
        if (!ok || o_rest !== 9'(N2)) begin
            n_err++;
            $display("FAIL auto2_ready: ok=%0d rest=%0d, required ok=1 rest=%0d", ok, o_rest, N2);
        end
`else
        n_cmp++;
        if (o_pronto !== 1'b1 || o_vazio !== 1'b1) begin
            n_err++;
            $display("FAIL two_empty: pronto=%b vazio=%b, required 1 1", o_pronto, o_vazio);
        end
`endif
        sel = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        emb = 1'b0;
        req = 1'b0;
        sel = 1'b0;
        test_reset();
        test_shuffle_draw();
        test_after_last();
        test_reproducibility();
        test_abort();
        test_reset_mid_shuffle();
        test_two_decks_seed0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
